// File: rtl/com_config_scan_sequencer.sv
// Serialises a selected FW configuration array into the ASIC scan chain, MSB-first,
// with a divided scan clock, followed by a parallel-load strobe and a done pulse.
module com_config_scan_sequencer #(
    parameter int NUM_WORDS = 256,
    parameter int WORD_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter int AW        = $clog2(NUM_WORDS)
) (
    input  logic                        fw_clk_100,
    input  logic                        fw_rst_n,
    input  logic                        op_code_w_reset,
    input  logic                        start,
    input  logic                        array_sel,
    input  logic [AW-1:0]               num_words_m1,
    input  logic [NUM_WORDS*WORD_W-1:0] config_array_0,
    input  logic [NUM_WORDS*WORD_W-1:0] config_array_1,
    output logic                        scan_clk,
    output logic                        scan_in,
    output logic                        scan_load,
    output logic                        busy,
    output logic                        done,
    output logic [AW-1:0]               word_idx
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

    state_t            state, state_nx;
    logic              sel, sel_nx;
    logic [AW-1:0]     last, last_nx, idx_nx, idx_inc;
    logic [WORD_W-1:0] shreg, shreg_nx, first_word, next_word;
    logic [DW-1:0]     div_cnt, div_nx;
    logic [BW-1:0]     bit_cnt, bit_nx;
    logic              phase_end;
    logic              scan_clk_nx, scan_in_nx, scan_load_nx, busy_nx, done_nx;

    // Words are fetched only at word boundaries, so edits to the word in flight are invisible.
    always_comb begin
        idx_inc    = word_idx + 1'b1;
        first_word = array_sel ? config_array_1[0 +: WORD_W] : config_array_0[0 +: WORD_W];
        next_word  = sel ? config_array_1[int'(idx_inc)*WORD_W +: WORD_W]
                         : config_array_0[int'(idx_inc)*WORD_W +: WORD_W];
    end

    always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= '0;
            word_idx <= '0;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            last     <= last_nx;
            word_idx <= idx_nx;
            shreg    <= shreg_nx;
            div_cnt  <= div_nx;
            bit_cnt  <= bit_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        last_nx   = last;
        idx_nx    = word_idx;
        shreg_nx  = shreg;
        bit_nx    = bit_cnt;
        div_nx    = div_cnt;
        phase_end = (div_cnt == DIV_LAST);
        if (state != IDLE) div_nx = phase_end ? '0 : div_cnt + 1'b1;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sel_nx   = array_sel;
                    last_nx  = num_words_m1;
                    idx_nx   = '0;
                    bit_nx   = '0;
                    div_nx   = '0;
                    shreg_nx = first_word;
                    state_nx = SHIFT_LO;
                end
            end
            SHIFT_LO: if (phase_end) state_nx = SHIFT_HI;
            SHIFT_HI: begin
                if (phase_end) begin
                    if (bit_cnt != BIT_LAST) begin
                        shreg_nx = shreg << 1;
                        bit_nx   = bit_cnt + 1'b1;
                        state_nx = SHIFT_LO;
                    end else if (word_idx != last) begin
                        idx_nx   = idx_inc;
                        bit_nx   = '0;
                        shreg_nx = next_word;
                        state_nx = SHIFT_LO;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: if (phase_end) state_nx = DONE;
            DONE: begin
                idx_nx   = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort discards the partial chain: no load strobe, no done pulse.
        if (op_code_w_reset) begin
            state_nx = IDLE;
            sel_nx   = 1'b0;
            last_nx  = '0;
            idx_nx   = '0;
            shreg_nx = '0;
            bit_nx   = '0;
            div_nx   = '0;
        end
    end

    // Outputs are registered from next-state values so they align with the state register.
    always_comb begin
        scan_clk_nx  = (state_nx == SHIFT_HI);
        scan_in_nx   = (state_nx == SHIFT_LO || state_nx == SHIFT_HI) ? shreg_nx[WORD_W-1] : 1'b0;
        scan_load_nx = (state_nx == LOAD);
        busy_nx      = (state_nx != IDLE);
        done_nx      = (state_nx == DONE);
    end

    always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            scan_clk  <= 1'b0;
            scan_in   <= 1'b0;
            scan_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            scan_clk  <= scan_clk_nx;
            scan_in   <= scan_in_nx;
            scan_load <= scan_load_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: doc/com_config_scan_sequencer.md
Name: com_config_scan_sequencer

Overview:
- Sequences delivery of the FW-side configuration arrays (config_array_0 / config_array_1, 256 x 16-bit) into the ASIC's serial configuration scan chain.
- On a start pulse from the op-code decoder, it walks the selected array word by word and shifts each word out MSB-first on scan_in with a divided scan_clk.
- After the last bit it pulses scan_load, then reports done.
- Sits between the write-register bank and the chip pads; owns the only path to the scan chain.

Parameters:
- NUM_WORDS, 256, number of words per config array; index width AW = $clog2(NUM_WORDS).
- WORD_W, 16, bits per config word.
- CLK_DIV, 4, fw_clk_100 cycles per scan_clk half-period; legal range 1..255.

Ports:
- fw_clk_100, input, 1, FW clock 100 MHz (S_AXI_ACLK); single clock domain.
- fw_rst_n, input, 1, asynchronous active-low reset (S_AXI_ARESETN).
- op_code_w_reset, input, 1, synchronous abort/clear, active high.
- start, input, 1, single-cycle request to begin a scan sequence.
- array_sel, input, 1, 0 = config_array_0, 1 = config_array_1; sampled with start.
- num_words_m1, input, AW, number of words to shift minus 1; sampled with start.
- config_array_0, input, NUM_WORDS x WORD_W packed, configuration array 0.
- config_array_1, input, NUM_WORDS x WORD_W packed, configuration array 1.
- scan_clk, output, 1, scan clock to ASIC; ASIC samples scan_in on its rising edge.
- scan_in, output, 1, serial data to ASIC.
- scan_load, output, 1, parallel-load strobe to ASIC.
- busy, output, 1, sequence in progress.
- done, output, 1, one-cycle completion pulse.
- word_idx, output, AW, index of the word currently being shifted.

Behaviour:
- Reset (fw_rst_n low, asynchronous): state IDLE; all outputs 0; internal counters and shift register cleared.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE. All outputs are registered.
- IDLE:
  - start=1 latches array_sel and num_words_m1, sets word_idx=0 and bit count=0, loads shreg from sel_array[0], and moves to SHIFT_LO.
  - busy rises on the next cycle.
- SHIFT_LO:
  - scan_clk=0, scan_in=shreg[WORD_W-1].
  - Held for CLK_DIV cycles, then moves to SHIFT_HI.
- SHIFT_HI:
  - scan_clk=1, scan_in unchanged.
  - Held for CLK_DIV cycles, then at the end of the phase:
    - Bit not last in word: shreg shifts left by 1, return to SHIFT_LO.
    - Last bit, word_idx != latched num_words_m1: word_idx+1, load shreg from sel_array[word_idx+1], return to SHIFT_LO.
    - Last bit of last word: go to LOAD.
- Data stability: scan_in changes only on SHIFT_HI to SHIFT_LO transitions, giving >= CLK_DIV cycles of setup and hold around each rising scan_clk.
- LOAD: scan_clk=0, scan_in=0, scan_load=1 for CLK_DIV cycles, then DONE.
- DONE: scan_load=0, done=1 for exactly one cycle, busy still 1; next state IDLE, where busy=0 and word_idx=0.
- Latency: first busy cycle through DONE inclusive = (num_words_m1+1) * WORD_W * 2 * CLK_DIV + CLK_DIV + 1 cycles.
- Boundary conditions:
  - start while busy: ignored; no re-latch.
  - start and op_code_w_reset in the same cycle: reset wins, remain IDLE.
  - op_code_w_reset in any state: next cycle IDLE, all outputs 0, no done pulse, no scan_load. The partial chain contents are discarded by the ASIC because no load occurs.
  - Config arrays are sampled per word at the word boundary. Changes to a word already loaded into shreg do not affect the bits in flight.
  - num_words_m1 = NUM_WORDS-1 shifts the full array. Do not wrap word_idx past NUM_WORDS-1.
  - fw_rst_n asserted mid-sequence: immediate asynchronous clear to the reset values.

Test Plan:
- Single word: CLK_DIV=2, array_sel=0, num_words_m1=0, config_array_0[0]=16'hA5C3, start at cycle 0.
  - scan_in at the 16 scan_clk rising edges = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - busy high cycles 1..67; scan_load high cycles 65..66; done high at cycle 67 only.
- Multi-word, array 1: CLK_DIV=1, array_sel=1, num_words_m1=2, config_array_1[0..2]=16'h0001, 16'h8000, 16'hFFFF.
  - 48 rising edges; word_idx steps 0, 1, 2 at each 16-bit boundary; bitstream matches; done after 96+1+1 cycles.
- Abort: op_code_w_reset at bit 5 of word 0 -> next cycle all outputs 0, IDLE, no done, no scan_load; a new start then runs cleanly.
- start during busy: second start mid-shift with array_sel flipped -> ignored, bitstream and timing unchanged.
- Full array at default CLK_DIV=4: num_words_m1=255, config_array_0[i]=i ^ 16'h5A5A.
  - 4096 rising edges; the final word index is 255.
  - busy length = 32768 + 5 cycles.
- Async reset mid-LOAD: fw_rst_n pulsed low -> scan_load, busy, scan_clk, and done go 0 immediately without waiting for a clock edge; state IDLE after release.
